ctrl_time_capture_12: RTL and testbench

Switching-event recorder: observes a 1-bit switching signal against the shared 12-bit simulation step counter and records up to 12 transitions as (time, value) slot pairs. The pairs are in the same format that the 12-slot time-scheduled switching controller consumes, so a captured waveform can be replayed bit-exactly. It sits beside the switch-control path, on the same `clk` and `counter`, and feeds the slot registers or host readback.

---
 rtl/ctrl_time_capture_12.sv | 146 ++++++++++++++
 tb/tb_ctrl_time_capture_12.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_time_capture_12.sv
// Switching-event recorder: captures up to 12 (time, value) transitions of x
// against the shared step counter, in the replay scheduler's slot format.
module ctrl_time_capture_12 (
   input  logic        clk,
   input  logic        sta,
   input  logic [11:0] counter,
   input  logic        x,
   input  logic        arm,
   input  logic [11:0] stop_time,
   output logic [11:0] time_1,
   output logic [11:0] time_2,
   output logic [11:0] time_3,
   output logic [11:0] time_4,
   output logic [11:0] time_5,
   output logic [11:0] time_6,
   output logic [11:0] time_7,
   output logic [11:0] time_8,
   output logic [11:0] time_9,
   output logic [11:0] time_10,
   output logic [11:0] time_11,
   output logic [11:0] time_12,
   output logic        value_1,
   output logic        value_2,
   output logic        value_3,
   output logic        value_4,
   output logic        value_5,
   output logic        value_6,
   output logic        value_7,
   output logic        value_8,
   output logic        value_9,
   output logic        value_10,
   output logic        value_11,
   output logic        value_12,
   output logic [3:0]  n_evt,
   output logic        busy,
   output logic        done,
   output logic        ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CAPT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q;
   logic [11:0] time_q [12];
   logic [11:0] value_q;
   logic [3:0]  wr_ptr_q;
   logic        x_q;
   logic        busy_q;
   logic        done_q;
   logic        ovf_q;

   logic        trans;
   logic        full;
   logic        at_stop;
   logic [11:0] stamp;

   assign trans   = (x != x_q);
   assign full    = (wr_ptr_q == 4'd12);
   assign at_stop = (counter == stop_time);
   // +1 lines the stamp up with the replay trigger at counter == time-1
   assign stamp   = counter + 12'd1;

   always_ff @(posedge clk or posedge sta) begin
      if (sta) begin
         state_q  <= IDLE;
         for (int i = 0; i < 12; i++) time_q[i] <= 12'h000;
         value_q  <= 12'h000;
         wr_ptr_q <= 4'd0;
         x_q      <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         x_q <= x;
         case (state_q)
            IDLE, DONE: begin
               if (arm) begin
                  for (int i = 0; i < 12; i++) time_q[i] <= 12'h000;
                  value_q  <= 12'h000;
                  wr_ptr_q <= 4'd0;
                  ovf_q    <= 1'b0;
                  busy_q   <= 1'b1;
                  done_q   <= 1'b0;
                  state_q  <= CAPT;
               end else if (state_q == DONE && trans && full) begin
                  ovf_q <= 1'b1;
               end
            end
            CAPT: begin
               if (trans) begin
                  if (!full) begin
                     time_q[wr_ptr_q]  <= stamp;
                     value_q[wr_ptr_q] <= x;
                     wr_ptr_q          <= wr_ptr_q + 4'd1;
                  end else begin
                     ovf_q <= 1'b1;
                  end
               end
               if (at_stop || full) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign time_1   = time_q[0];
   assign time_2   = time_q[1];
   assign time_3   = time_q[2];
   assign time_4   = time_q[3];
   assign time_5   = time_q[4];
   assign time_6   = time_q[5];
   assign time_7   = time_q[6];
   assign time_8   = time_q[7];
   assign time_9   = time_q[8];
   assign time_10  = time_q[9];
   assign time_11  = time_q[10];
   assign time_12  = time_q[11];
   assign value_1  = value_q[0];
   assign value_2  = value_q[1];
   assign value_3  = value_q[2];
   assign value_4  = value_q[3];
   assign value_5  = value_q[4];
   assign value_6  = value_q[5];
   assign value_7  = value_q[6];
   assign value_8  = value_q[7];
   assign value_9  = value_q[8];
   assign value_10 = value_q[9];
   assign value_11 = value_q[10];
   assign value_12 = value_q[11];
   assign n_evt    = wr_ptr_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_ctrl_time_capture_12.sv
// Bench for ctrl_time_capture_12: directed scenarios plus random capture
// rounds, checked against an event-list reference model.
module tb_ctrl_time_capture_12;

   logic        clk = 1'b0;
   logic        sta = 1'b1;
   logic [11:0] cnt = 12'd0;
   logic        x = 1'b0;
   logic        arm = 1'b0;
   logic [11:0] stp = 12'd0;
   logic [11:0] t_o [12];
   logic        v_o [12];
   logic [3:0]  n_evt;
   logic        busy, done, ovf;

   int n_chk = 0;
   int n_err = 0;

   // reference model: capture window as an event list
   int          m_mode = 0;
   logic        m_prev = 1'b0;
   logic        m_ovf = 1'b0;
   logic [11:0] mq_t [$];
   logic        mq_v [$];

   always #5 clk = ~clk;

   ctrl_time_capture_12 dut (
      .clk(clk), .sta(sta), .counter(cnt), .x(x), .arm(arm),
      .stop_time(stp),
      .time_1(t_o[0]), .time_2(t_o[1]), .time_3(t_o[2]),
      .time_4(t_o[3]), .time_5(t_o[4]), .time_6(t_o[5]),
      .time_7(t_o[6]), .time_8(t_o[7]), .time_9(t_o[8]),
      .time_10(t_o[9]), .time_11(t_o[10]), .time_12(t_o[11]),
      .value_1(v_o[0]), .value_2(v_o[1]), .value_3(v_o[2]),
      .value_4(v_o[3]), .value_5(v_o[4]), .value_6(v_o[5]),
      .value_7(v_o[6]), .value_8(v_o[7]), .value_9(v_o[8]),
      .value_10(v_o[9]), .value_11(v_o[10]), .value_12(v_o[11]),
      .n_evt(n_evt), .busy(busy), .done(done), .ovf(ovf)
   );

   task automatic chk(input string tag, input logic [159:0] obs,
                      input logic [159:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      logic changed;
      changed = (x != m_prev);
      m_prev  = x;
      if (sta) begin
         m_mode = 0; m_ovf = 1'b0; m_prev = 1'b0;
         mq_t.delete(); mq_v.delete();
      end else if (m_mode != 1 && arm) begin
         m_mode = 1; m_ovf = 1'b0;
         mq_t.delete(); mq_v.delete();
      end else if (m_mode == 1) begin
         int sz;
         sz = mq_t.size();
         if (changed) begin
            if (sz < 12) begin
               mq_t.push_back(12'((int'(cnt) + 1) % 4096));
               mq_v.push_back(x);
            end else m_ovf = 1'b1;
         end
         if (cnt == stp || sz == 12) m_mode = 2;
      end else if (m_mode == 2) begin
         if (changed && mq_t.size() == 12) m_ovf = 1'b1;
      end
   endtask

   function automatic logic [159:0] slots_obs();
      logic [159:0] r;
      r = '0;
      for (int k = 0; k < 12; k++) r[k*13 +: 13] = {t_o[k], v_o[k]};
      return r;
   endfunction

   function automatic logic [159:0] slots_exp();
      logic [159:0] r;
      r = '0;
      for (int k = 0; k < mq_t.size(); k++)
         r[k*13 +: 13] = {mq_t[k], mq_v[k]};
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("busy", 160'(busy), 160'(m_mode == 1));
      chk("done", 160'(done), 160'(m_mode == 2));
      chk("ovf", 160'(ovf), 160'(m_ovf));
      chk("n_evt", 160'(n_evt), 160'(mq_t.size()));
      chk("slots", slots_obs(), slots_exp());
      cnt = cnt + 12'd1;
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   logic xs [0:127];
   logic lvl;
   int   bad;

   initial begin
      // reset held three cycles with x toggling
      for (int i = 0; i < 3; i++) begin
         x = ~x;
         tick();
      end
      chk("rst_n_evt", 160'(n_evt), 160'(0));
      chk("rst_slots", slots_obs(), 160'(0));
      sta = 1'b0;
      x = 1'b0;
      tick();

      // basic capture
      stp = 12'd100;
      cnt = 12'd0;
      pulse_arm();
      while (cnt != 12'd105) begin
         x = (cnt >= 12'd10 && cnt < 12'd25);
         xs[cnt[6:0]] = x;
         tick();
      end
      chk("b_t1", 160'(t_o[0]), 160'(11));
      chk("b_v1", 160'(v_o[0]), 160'(1));
      chk("b_t2", 160'(t_o[1]), 160'(26));
      chk("b_v2", 160'(v_o[1]), 160'(0));
      chk("b_n", 160'(n_evt), 160'(2));
      chk("b_flags", 160'({done, busy, ovf}), 160'(3'b100));

      // loopback: replay from slots must equal x delayed one count
      lvl = 1'b0;
      bad = 0;
      for (int c = 2; c <= 100; c++) begin
         for (int k = 0; k < 12; k++)
            if (k < int'(n_evt) && int'(t_o[k]) == c) lvl = v_o[k];
         if (lvl !== xs[c-1]) bad++;
      end
      chk("loopback", 160'(bad), 160'(0));

      // full plus overflow
      stp = 12'd4000;
      cnt = 12'd0;
      x = 1'b0;
      pulse_arm();
      while (cnt != 12'd40) begin
         x = (cnt >= 12'd4) ? ~((cnt - 12'd4) >> 1) & 1'b1 : 1'b0;
         x = (cnt >= 12'd4) ? (((cnt - 12'd4) >> 1) % 2 == 0) : 1'b0;
         tick();
         if (cnt == 12'd27) chk("f_busy_at12", 160'(busy), 160'(1));
         if (cnt == 12'd28) chk("f_done", 160'(done), 160'(1));
      end
      for (int k = 0; k < 12; k++) begin
         chk("f_time", 160'(t_o[k]), 160'(5 + 2*k));
         chk("f_val", 160'(v_o[k]), 160'(k % 2 == 0));
      end
      chk("f_ovf", 160'(ovf), 160'(1));

      // wrap
      stp = 12'd50;
      cnt = 12'd4090;
      x = 1'b0;
      pulse_arm();
      for (int i = 0; i < 70; i++) begin
         x = (cnt == 12'hFFF || cnt < 12'd3);
         tick();
      end
      chk("w_t1", 160'(t_o[0]), 160'(0));
      chk("w_t2", 160'(t_o[1]), 160'(4));
      chk("w_n", 160'(n_evt), 160'(2));

      // event on the stop cycle
      stp = 12'd60;
      cnt = 12'd40;
      x = 1'b0;
      pulse_arm();
      for (int i = 0; i < 25; i++) begin
         x = (cnt >= 12'd60);
         tick();
         if (cnt == 12'd61) begin
            chk("s_t1", 160'(t_o[0]), 160'(61));
            chk("s_done", 160'(done), 160'(1));
         end
      end

      // mid-capture reset after three events
      stp = 12'd500;
      cnt = 12'd0;
      x = 1'b0;
      pulse_arm();
      for (int i = 0; i < 8; i++) begin
         x = (i >= 2 && i < 4) || (i >= 6);
         tick();
      end
      chk("m_n3", 160'(n_evt), 160'(3));
      #2 sta = 1'b1;
      #1 chk("m_async", 160'({busy, n_evt}), 160'(0));
      tick();
      chk("m_slots", slots_obs(), 160'(0));
      sta = 1'b0;
      x = 1'b0;
      tick();
      pulse_arm();
      for (int i = 0; i < 10; i++) begin
         x = (i >= 3);
         tick();
      end
      chk("m_rearm", 160'(n_evt), 160'(1));

      // random rounds
      for (int r = 0; r < 12; r++) begin
         stp = cnt + 12'($urandom_range(5, 70));
         x = 1'($urandom);
         pulse_arm();
         for (int i = 0; i < 90; i++) begin
            if ($urandom_range(0, 2) == 0) x = ~x;
            arm = ($urandom_range(0, 29) == 0);
            tick();
         end
         arm = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
